// File: rtl/usb3_tx_writer.sv
// Upload-direction FX3 slave-FIFO master: streams 32-bit source words into the
// GPIF-II write socket in fixed bursts and closes short packets after an idle timeout.
module usb3_tx_writer #(
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned FLAG_DELAY = 3,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [1:0]  TX_ADDR    = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic        USB3_FLAGB,
  output logic        USB3_SLCS_N,
  output logic        USB3_SLWR_N,
  output logic        USB3_PKTEND_N,
  output logic [1:0]  USB3_A,
  output logic [31:0] USB3_DQ_out,
  output logic        USB3_DQ_oe,
  output logic [3:0]  usb_wr_state,
  output logic [31:0] words_sent,
  output logic        overflow_err
);

  localparam int unsigned BW   = $clog2(BURST_LEN) + 1;
  localparam int unsigned IW   = $clog2(TIMEOUT) + 1;
  localparam int unsigned CMAX = (FLAG_DELAY > GAP_CYCLES) ? FLAG_DELAY : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX) + 1;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR   = 4'd1,
    S_CHECK  = 4'd2,
    S_WRITE  = 4'd3,
    S_PKTEND = 4'd4,
    S_GAP    = 4'd5
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_burst_cnt;
  logic [IW-1:0] r_idle_cnt;
  logic [CW-1:0] r_wait_cnt;
  logic          r_slcs_n;
  logic          r_slwr_n;
  logic          r_pktend_n;
  logic [1:0]    r_a;
  logic [31:0]   r_dq;
  logic          r_dq_oe;
  logic [31:0]   r_words_sent;
  logic          r_overflow;

  logic          w_ready;
  logic          w_last_word;
  logic          w_idle_expired;

  // Acceptance is combinational so the source sees back-pressure the same cycle FLAGB drops.
  assign w_ready        = (r_state == S_WRITE) && USB3_FLAGB;
  assign w_last_word    = (r_burst_cnt == BW'(BURST_LEN - 1));
  assign w_idle_expired = (r_idle_cnt >= IW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_burst_cnt  <= '0;
      r_idle_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_slcs_n     <= 1'b1;
      r_slwr_n     <= 1'b1;
      r_pktend_n   <= 1'b1;
      r_a          <= 2'b00;
      r_dq         <= '0;
      r_dq_oe      <= 1'b0;
      r_words_sent <= '0;
      r_overflow   <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below.
      r_slwr_n   <= 1'b1;
      r_pktend_n <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_slcs_n <= 1'b1;
          r_dq_oe  <= 1'b0;
          r_a      <= 2'b00;
          if (src_valid) begin
            r_state    <= S_ADDR;
            r_slcs_n   <= 1'b0;
            r_a        <= TX_ADDR;
            r_dq_oe    <= 1'b1;
            r_wait_cnt <= '0;
          end
        end

        S_ADDR: begin
          if (r_wait_cnt == CW'(FLAG_DELAY - 1)) begin
            r_state    <= S_CHECK;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end

        S_CHECK: begin
          if (USB3_FLAGB) begin
            r_state     <= S_WRITE;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
          end
        end

        S_WRITE: begin
          if (!USB3_FLAGB) begin
            r_overflow <= 1'b1;
            r_state    <= S_GAP;
            r_wait_cnt <= '0;
            r_slcs_n   <= 1'b1;
            r_dq_oe    <= 1'b0;
            r_a        <= 2'b00;
          end else if (src_valid) begin
            r_dq         <= src_data;
            r_slwr_n     <= 1'b0;
            r_burst_cnt  <= r_burst_cnt + BW'(1);
            r_words_sent <= r_words_sent + 32'd1;
            r_idle_cnt   <= '0;
            // Full buffer auto-commits; chip select stays low for this final strobe.
            if (w_last_word) begin
              r_state    <= S_GAP;
              r_wait_cnt <= '0;
            end
          end else begin
            if (r_idle_cnt != {IW{1'b1}}) begin
              r_idle_cnt <= r_idle_cnt + IW'(1);
            end
            if (w_idle_expired) begin
              if (r_burst_cnt != '0) begin
                r_state    <= S_PKTEND;
                r_pktend_n <= 1'b0;
              end else begin
                r_state    <= S_GAP;
                r_wait_cnt <= '0;
                r_slcs_n   <= 1'b1;
                r_dq_oe    <= 1'b0;
                r_a        <= 2'b00;
              end
            end
          end
        end

        S_PKTEND: begin
          r_state    <= S_GAP;
          r_wait_cnt <= '0;
          r_slcs_n   <= 1'b1;
          r_dq_oe    <= 1'b0;
          r_a        <= 2'b00;
        end

        S_GAP: begin
          r_slcs_n <= 1'b1;
          r_dq_oe  <= 1'b0;
          r_a      <= 2'b00;
          if (r_wait_cnt == CW'(GAP_CYCLES - 1)) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign src_ready     = w_ready;
  assign USB3_SLCS_N   = r_slcs_n;
  assign USB3_SLWR_N   = r_slwr_n;
  assign USB3_PKTEND_N = r_pktend_n;
  assign USB3_A        = r_a;
  assign USB3_DQ_out   = r_dq;
  assign USB3_DQ_oe    = r_dq_oe;
  assign usb_wr_state  = r_state;
  assign words_sent    = r_words_sent;
  assign overflow_err  = r_overflow;

endmodule

// File: tb/tb_usb3_tx_writer.sv
// Directed + randomized bench for usb3_tx_writer: a word scoreboard plus pin-level
// observations (strobe counts, PKTEND spacing, ADDR/GAP lengths) against expected values.
module tb_usb3_tx_writer;

  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        USB3_FLAGB;
  logic        USB3_SLCS_N;
  logic        USB3_SLWR_N;
  logic        USB3_PKTEND_N;
  logic [1:0]  USB3_A;
  logic [31:0] USB3_DQ_out;
  logic        USB3_DQ_oe;
  logic [3:0]  usb_wr_state;
  logic [31:0] words_sent;
  logic        overflow_err;

  always #5 clk = ~clk;

  usb3_tx_writer #(
    .BURST_LEN (256),
    .FLAG_DELAY(3),
    .TIMEOUT   (TIMEOUT),
    .GAP_CYCLES(4),
    .TX_ADDR   (2'b11)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .USB3_FLAGB   (USB3_FLAGB),
    .USB3_SLCS_N  (USB3_SLCS_N),
    .USB3_SLWR_N  (USB3_SLWR_N),
    .USB3_PKTEND_N(USB3_PKTEND_N),
    .USB3_A       (USB3_A),
    .USB3_DQ_out  (USB3_DQ_out),
    .USB3_DQ_oe   (USB3_DQ_oe),
    .usb_wr_state (usb_wr_state),
    .words_sent   (words_sent),
    .overflow_err (overflow_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc, acc_cnt, pk_cnt, pk_cyc, last_wr;
  int addr_run, last_addr, gap_run, last_gap, dly;
  bit dly_loaded;
  logic [31:0] q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          dq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_sb();
    q.delete(); dq.delete(); exp_q.delete(); obs_q.delete();
    acc_cnt = 0; pk_cnt = 0; pk_cyc = -1; last_wr = -1;
    addr_run = 0; last_addr = 0; gap_run = 0; last_gap = 0;
    dly = 0; dly_loaded = 1'b0;
  endtask

  task automatic load(input int n, input int d);
    for (int i = 0; i < n; i++) begin
      q.push_back($urandom);
      dq.push_back(d);
    end
  endtask

  // One clock: observe pins at negedge, drive the source, record the handshake at posedge.
  task automatic tick();
    bit acc;
    @(negedge clk);
    cyc++;
    if (USB3_SLWR_N === 1'b0) begin
      chk("wr_cs", 32'(USB3_SLCS_N), 32'd0);
      chk("wr_addr", 32'(USB3_A), 32'd3);
      obs_q.push_back(USB3_DQ_out);
      last_wr = cyc;
    end
    if (USB3_PKTEND_N === 1'b0) begin
      pk_cnt++;
      pk_cyc = cyc;
      chk("pkt_wr", 32'(USB3_SLWR_N), 32'd1);
    end
    if (usb_wr_state == 4'd1) addr_run++;
    else if (addr_run != 0) begin last_addr = addr_run; addr_run = 0; end
    if (usb_wr_state == 4'd5) gap_run++;
    else if (gap_run != 0) begin last_gap = gap_run; gap_run = 0; end
    if (q.size() != 0 && !dly_loaded) begin dly = dq[0]; dly_loaded = 1'b1; end
    if (q.size() == 0) src_valid = 1'b0;
    else if (dly > 0) begin src_valid = 1'b0; dly--; end
    else begin src_valid = 1'b1; src_data = q[0]; end
    #1;
    acc = src_valid && src_ready;
    @(posedge clk);
    if (acc) begin
      exp_q.push_back(q.pop_front());
      void'(dq.pop_front());
      dly_loaded = 1'b0;
      acc_cnt++;
    end
    #1;
  endtask

  task automatic run_idle(input string tag, input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      tick();
      if (q.size() == 0 && usb_wr_state == 4'd0) done = 1'b1;
    end
    repeat (2) tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({tag, "_dq"}, obs_q[i], exp_q[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_sb();
    repeat (2) tick();
    rst = 1'b0;
    clear_sb();
  endtask

  initial begin
    bit hit;
    int n;
    cyc = 0; rst = 1'b1; src_valid = 1'b0; src_data = '0; USB3_FLAGB = 1'b1;
    do_reset();
    chk("rst_slcs", 32'(USB3_SLCS_N), 32'd1);
    chk("rst_slwr", 32'(USB3_SLWR_N), 32'd1);
    chk("rst_pkt", 32'(USB3_PKTEND_N), 32'd1);
    chk("rst_a", 32'(USB3_A), 32'd0);
    chk("rst_dq", USB3_DQ_out, 32'd0);
    chk("rst_oe", 32'(USB3_DQ_oe), 32'd0);
    chk("rst_ready", 32'(src_ready), 32'd0);
    chk("rst_state", 32'(usb_wr_state), 32'd0);
    chk("rst_words", words_sent, 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);

    // Full burst auto-commits without PKTEND.
    load(256, 0);
    run_idle("t1", 1500);
    cmp_stream("t1");
    chk("t1_pkt", 32'(pk_cnt), 32'd0);
    chk("t1_addr_len", 32'(last_addr), 32'd3);
    chk("t1_gap_len", 32'(last_gap), 32'd4);
    chk("t1_words", words_sent, 32'd256);
    chk("t1_ovf", 32'(overflow_err), 32'd0);

    // Short packet closed by PKTEND one timeout after the last strobe.
    do_reset();
    load(10, 0);
    run_idle("t2", 400);
    cmp_stream("t2");
    chk("t2_pkt", 32'(pk_cnt), 32'd1);
    chk("t2_pkt_dist", 32'(pk_cyc - last_wr), 32'(TIMEOUT));
    chk("t2_words", words_sent, 32'd10);
    chk("t2_gap_len", 32'(last_gap), 32'd4);

    // Back-pressure in CHECK.
    do_reset();
    USB3_FLAGB = 1'b0;
    load(20, 0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (usb_wr_state == 4'd2) hit = 1'b1;
    end
    chk("t3_reach_check", 32'(hit), 32'd1);
    repeat (50) tick();
    chk("t3_no_wr", 32'(obs_q.size()), 32'd0);
    chk("t3_no_acc", 32'(acc_cnt), 32'd0);
    chk("t3_hold", 32'(usb_wr_state), 32'd2);
    USB3_FLAGB = 1'b1;
    tick();
    chk("t3_start", 32'(usb_wr_state), 32'd3);
    run_idle("t3", 400);
    cmp_stream("t3");
    chk("t3_pkt", 32'(pk_cnt), 32'd1);
    chk("t3_words", words_sent, 32'd20);

    // FLAGB drops mid-burst.
    do_reset();
    load(300, 0);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      if (acc_cnt == 100) hit = 1'b1;
    end
    chk("t4_reach100", 32'(hit), 32'd1);
    USB3_FLAGB = 1'b0;
    #1;
    chk("t4_ready_drop", 32'(src_ready), 32'd0);
    chk("t4_in_write", 32'(usb_wr_state), 32'd3);
    tick();
    chk("t4_gap", 32'(usb_wr_state), 32'd5);
    chk("t4_ovf", 32'(overflow_err), 32'd1);
    repeat (10) tick();
    chk("t4_ovf_sticky", 32'(overflow_err), 32'd1);
    chk("t4_words", words_sent, 32'd100);
    chk("t4_pkt", 32'(pk_cnt), 32'd0);
    cmp_stream("t4");
    USB3_FLAGB = 1'b1;

    // Reset mid-burst abandons the buffer.
    do_reset();
    chk("t5_ovf_cleared", 32'(overflow_err), 32'd0);
    load(300, 0);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      if (acc_cnt == 37) hit = 1'b1;
    end
    chk("t5_reach37", 32'(hit), 32'd1);
    chk("t5_words_pre", words_sent, 32'd37);
    rst = 1'b1;
    q.delete(); dq.delete();
    tick();
    chk("t5_slwr", 32'(USB3_SLWR_N), 32'd1);
    chk("t5_slcs", 32'(USB3_SLCS_N), 32'd1);
    chk("t5_oe", 32'(USB3_DQ_oe), 32'd0);
    chk("t5_words", words_sent, 32'd0);
    chk("t5_state", 32'(usb_wr_state), 32'd0);
    rst = 1'b0;
    repeat (80) tick();
    chk("t5_pkt", 32'(pk_cnt), 32'd0);
    chk("t5_idle", 32'(usb_wr_state), 32'd0);

    // Gapped source: idle runs stay below the timeout, burst auto-commits.
    do_reset();
    load(256, 2);
    run_idle("t6", 1500);
    cmp_stream("t6");
    chk("t6_pkt", 32'(pk_cnt), 32'd0);
    chk("t6_words", words_sent, 32'd256);

    // 63 idle cycles then a word: the accept beats the expiring timer.
    do_reset();
    load(2, 0);
    load(1, TIMEOUT - 1);
    run_idle("t7", 600);
    cmp_stream("t7");
    chk("t7_pkt", 32'(pk_cnt), 32'd1);
    chk("t7_pkt_dist", 32'(pk_cyc - last_wr), 32'(TIMEOUT));
    chk("t7_words", words_sent, 32'd3);

    // 64 idle cycles: first packet commits, the late word opens a second one.
    do_reset();
    load(1, 0);
    load(1, TIMEOUT);
    run_idle("t8", 800);
    cmp_stream("t8");
    chk("t8_pkt", 32'(pk_cnt), 32'd2);
    chk("t8_words", words_sent, 32'd2);

    // Random short packet with random inter-word gaps.
    do_reset();
    n = $urandom_range(1, 40);
    for (int i = 0; i < n; i++) load(1, $urandom_range(0, 5));
    run_idle("t9", 1200);
    cmp_stream("t9");
    chk("t9_pkt", 32'(pk_cnt), 32'd1);
    chk("t9_words", words_sent, 32'(n));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb3_tx_writer.md
Name: usb3_tx_writer

Overview:
- Upload-direction FX3 slave-FIFO master: moves 32-bit words from an internal source (valid/ready stream) to the USB3 host through the GPIF-II synchronous slave FIFO write port.
- Counterpart of the download path that reads the FX3 socket on USB3_FLAGA and fills the waveform RAMs.
- Sits between the capture/status FIFO and the FX3 pins.
- Writes fixed-size bursts while the FX3 reports buffer space, and commits partial packets with PKTEND after an idle timeout.

Parameters:
- BURST_LEN, 256, words per FX3 DMA buffer; one full burst fills exactly one buffer and auto-commits.
- FLAG_DELAY, 3, cycles to wait after driving the socket address before sampling USB3_FLAGB.
- TIMEOUT, 64, consecutive idle source cycles inside a burst before a short packet is committed.
- GAP_CYCLES, 4, idle cycles after any burst or PKTEND before the next address phase.
- TX_ADDR, 2'b11, FX3 socket address for the upload socket.

Ports:
- clk  in  1  system clock; also drives the FX3 PCLK domain.
- rst  in  1  synchronous reset, active-high.
- src_data  in  32  word to transmit.
- src_valid  in  1  src_data holds a valid word.
- src_ready  out  1  word accepted on a cycle where src_valid && src_ready.
- USB3_FLAGB  in  1  FX3 upload socket not-full (1 = space available).
- USB3_SLCS_N  out  1  FX3 chip select, active low.
- USB3_SLWR_N  out  1  FX3 write strobe, active low.
- USB3_PKTEND_N  out  1  FX3 packet-end strobe, active low.
- USB3_A  out  2  FX3 socket address.
- USB3_DQ_out  out  32  data driven onto the FX3 bus.
- USB3_DQ_oe  out  1  bus output enable (1 = FPGA drives DQ).
- usb_wr_state  out  4  current state encoding, for debug.
- words_sent  out  32  total accepted words; wraps modulo 2^32.
- overflow_err  out  1  sticky: USB3_FLAGB dropped mid-burst.

Behaviour:
Clocking, reset and output timing:
- All state changes occur on posedge clk. All FX3 outputs are registered.
- Reset values: SLCS_N=1, SLWR_N=1, PKTEND_N=1, A=2'b00, DQ_out=0, DQ_oe=0, src_ready=0, usb_wr_state=0, words_sent=0, overflow_err=0. All internal counters are cleared.
- rst asserted in any state returns the block to IDLE on the next edge with reset values, even mid-burst. A partially written buffer is not committed.
- src_ready is combinational: (state==WRITE) && USB3_FLAGB.

States and transitions:
- IDLE(0): outputs idle. When src_valid=1, go to ADDR.
- ADDR(1): SLCS_N=0, A=TX_ADDR, DQ_oe=1. Count FLAG_DELAY cycles, then go to CHECK.
- CHECK(2): if USB3_FLAGB=1, go to WRITE with burst_cnt=0 and idle_cnt=0. Otherwise remain in CHECK indefinitely.
- WRITE(3), on an accepted word:
  - DQ_out<=src_data, SLWR_N<=0 for that cycle.
  - burst_cnt++, words_sent++, idle_cnt<=0.
  - If the accepted word is number BURST_LEN (burst_cnt==BURST_LEN-1 before increment), go to GAP. The FX3 auto-commits; no PKTEND is issued.
- WRITE(3), on a cycle with src_valid=0:
  - SLWR_N<=1, idle_cnt++.
  - If idle_cnt reaches TIMEOUT-1 and burst_cnt>0, go to PKTEND.
  - If idle_cnt reaches TIMEOUT-1 and burst_cnt==0, go to GAP with no strobe.
- WRITE(3), when USB3_FLAGB=0: no word is accepted, SLWR_N<=1, overflow_err<=1, go to GAP.
- PKTEND(4): PKTEND_N=0 for exactly one cycle with SLWR_N=1, then go to GAP. A zero-length packet is never generated.
- GAP(5): SLWR_N=1, PKTEND_N=1, SLCS_N=1, DQ_oe=0. Hold for GAP_CYCLES, then go to IDLE.

Simultaneous events:
- A word accepted on the same cycle idle_cnt would expire: the accept wins and idle_cnt is cleared.
- USB3_FLAGB=0 together with src_valid=1: no accept (src_ready=0), and the FLAGB-drop rule applies.

Widths:
- burst_cnt is clog2(BURST_LEN)+1 bits.
- idle_cnt is clog2(TIMEOUT)+1 bits and saturates.

Test Plan:
1. Full burst: src_valid held 1, FLAGB=1 → ADDR for 3 cycles, 256 SLWR_N-low cycles with DQ equal to the source sequence, no PKTEND, 4-cycle GAP, words_sent=256.
2. Short packet: supply 10 words, then src_valid=0 → 10 writes, PKTEND_N low exactly once on the 64th idle cycle, words_sent=10.
3. Back-pressure: FLAGB=0 during CHECK for 50 cycles, then 1 → no SLWR_N activity while FLAGB=0; the burst starts on the cycle after FLAGB rises.
4. FLAGB drops after 100 words → src_ready falls the same cycle, overflow_err=1 and stays set, state reaches GAP, words_sent=100.
5. Reset at word 37 of a burst → next edge: SLWR_N=1, SLCS_N=1, DQ_oe=0, words_sent=0, state IDLE, no PKTEND.
6. Gapped source: one word every 3 cycles with TIMEOUT=64 → no PKTEND, 256 writes, the burst completes via auto-commit.
